// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: state encodings and streak counter sizing.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_I_WAIT = 2'd1,
        ARB_D_WAIT = 2'd2
    } arb_state_t;

    localparam int unsigned STREAK_W         = 4;
    localparam int unsigned STREAK_LIMIT_MAX = 15;

endpackage

// File: rtl/mem_arbiter_perf.sv
// Grant/conflict event counters for mem_arbiter; present only when MEM_ARB_PERF_EN is defined.
module mem_arbiter_perf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_acc,
    input  logic        d_acc,
    input  logic        conflict,
    output logic [31:0] perf_i_grants,
    output logic [31:0] perf_d_grants,
    output logic [31:0] perf_conflicts
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_i_grants  <= '0;
            perf_d_grants  <= '0;
            perf_conflicts <= '0;
        end else begin
            if (i_acc)    perf_i_grants  <= perf_i_grants + 32'd1;
            if (d_acc)    perf_d_grants  <= perf_d_grants + 32'd1;
            if (conflict) perf_conflicts <= perf_conflicts + 32'd1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Instruction/data arbiter onto a single-outstanding memory port with data-streak starvation guard.
// Optional counters (perf_* ports) are built when MEM_ARB_PERF_EN is defined.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_DATA_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inst_start,
    output logic        inst_ready,
    input  logic [31:0] i_addr,
    output logic [31:0] inst,
    output logic        inst_valid,
    input  logic        d_cmd_start,
    input  logic        d_cmd_write,
    output logic        d_cmd_ready,
    input  logic [31:0] d_addr,
    input  logic [31:0] wdata,
    input  logic [31:0] wmask,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        mem_cmd_start,
    output logic        mem_cmd_write,
    input  logic        mem_cmd_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [31:0] mem_wmask,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rdata_valid
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0] perf_i_grants,
    output logic [31:0] perf_d_grants,
    output logic [31:0] perf_conflicts
`endif
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

    arb_state_t          state_q, state_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                idle, grant_d, grant_i, i_acc, d_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ARB_IDLE;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
        end
    end

    always_comb begin
        // rst_n gates the outputs so handshakes stay low throughout reset
        idle          = rst_n && (state_q == ARB_IDLE);
        grant_d       = d_cmd_start && (!inst_start || (streak_q != STREAK_MAX));
        grant_i       = inst_start && !grant_d;

        mem_cmd_start = idle && (inst_start || d_cmd_start);
        mem_cmd_write = grant_d && d_cmd_write;
        mem_addr      = grant_d ? d_addr : i_addr;
        mem_wdata     = grant_d ? wdata  : '0;
        mem_wmask     = grant_d ? wmask  : '0;
        inst_ready    = idle && mem_cmd_ready && grant_i;
        d_cmd_ready   = idle && mem_cmd_ready && grant_d;
        i_acc         = inst_start && inst_ready;
        d_acc         = d_cmd_start && d_cmd_ready;

        inst          = mem_rdata;
        rdata         = mem_rdata;
        inst_valid    = rst_n && (state_q == ARB_I_WAIT) && mem_rdata_valid;
        rdata_valid   = rst_n && (state_q == ARB_D_WAIT) && mem_rdata_valid;

        state_d       = state_q;
        streak_d      = streak_q;
        case (state_q)
            ARB_IDLE: begin
                if (i_acc)                     state_d = ARB_I_WAIT;
                else if (d_acc && !d_cmd_write) state_d = ARB_D_WAIT;
                if (i_acc || !inst_start)
                    streak_d = '0;
                else if (d_acc && (streak_q != STREAK_MAX))
                    streak_d = streak_q + 1'b1;
            end
            ARB_I_WAIT: if (mem_rdata_valid) state_d = ARB_IDLE;
            ARB_D_WAIT: if (mem_rdata_valid) state_d = ARB_IDLE;
            default:    state_d = ARB_IDLE;
        endcase
    end

`ifdef MEM_ARB_PERF_EN
    logic conflict;
    assign conflict = idle && inst_start && d_cmd_start && mem_cmd_ready;

    mem_arbiter_perf u_perf (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_acc          (i_acc),
        .d_acc          (d_acc),
        .conflict       (conflict),
        .perf_i_grants  (perf_i_grants),
        .perf_d_grants  (perf_d_grants),
        .perf_conflicts (perf_conflicts)
    );
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios plus randomized traffic against a rule-level model.
module tb_mem_arbiter;

    localparam int MAX_STREAK = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        inst_start = 1'b0, d_cmd_start = 1'b0, d_cmd_write = 1'b0;
    logic        inst_ready, inst_valid, d_cmd_ready, rdata_valid;
    logic [31:0] i_addr = '0, d_addr = '0, wdata = '0, wmask = '0;
    logic [31:0] inst, rdata;
    logic        mem_cmd_start, mem_cmd_write;
    logic        mem_cmd_ready = 1'b0, mem_rdata_valid = 1'b0;
    logic [31:0] mem_addr, mem_wdata, mem_wmask;
    logic [31:0] mem_rdata = '0;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_i_grants, perf_d_grants, perf_conflicts;
`endif

    always #5 clk = ~clk;

    mem_arbiter #(.MAX_DATA_STREAK(MAX_STREAK)) dut (
        .clk(clk), .rst_n(rst_n),
        .inst_start(inst_start), .inst_ready(inst_ready), .i_addr(i_addr),
        .inst(inst), .inst_valid(inst_valid),
        .d_cmd_start(d_cmd_start), .d_cmd_write(d_cmd_write), .d_cmd_ready(d_cmd_ready),
        .d_addr(d_addr), .wdata(wdata), .wmask(wmask), .rdata(rdata), .rdata_valid(rdata_valid),
        .mem_cmd_start(mem_cmd_start), .mem_cmd_write(mem_cmd_write), .mem_cmd_ready(mem_cmd_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid)
`ifdef MEM_ARB_PERF_EN
        , .perf_i_grants(perf_i_grants), .perf_d_grants(perf_d_grants), .perf_conflicts(perf_conflicts)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Scoreboard queues of expected read responses
    logic [31:0] iq[$];
    logic [31:0] dq[$];

    // Reference model: outstanding flag, data streak, event counts
    bit          m_busy = 0;
    int          m_streak = 0;
    logic [31:0] m_pi = '0, m_pd = '0, m_pc = '0;

    // Memory model
    logic [31:0] mem_img[logic [31:0]];
    bit          mem_pend = 0;
    int unsigned mem_cnt = 0;
    logic [31:0] mem_resp = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] img(input logic [31:0] a);
        if (mem_img.exists(a)) return mem_img[a];
        return a ^ 32'h5A5A_0F0F ^ {a[15:0], a[31:16]};
    endfunction

    task automatic mem_start(input logic [31:0] a, input int unsigned lat);
        mem_pend = 1;
        mem_cnt  = lat - 1;
        mem_resp = img(a);
    endtask

    task automatic cycle(input bit is, input bit ds, input bit dw,
                         input logic [31:0] ia, input logic [31:0] da,
                         input logic [31:0] wd, input logic [31:0] wm,
                         input bit rdy, input int unsigned lat, input bit spur);
        bit gd, gi, vis;
        @(posedge clk); #1;
        if (mem_pend) begin
            if (mem_cnt == 0) begin
                mem_rdata_valid = 1'b1;
                mem_rdata       = mem_resp;
                mem_pend        = 0;
            end else begin
                mem_cnt--;
                mem_rdata_valid = 1'b0;
                mem_rdata       = $urandom;
            end
        end else begin
            mem_rdata_valid = spur && ($urandom_range(0, 7) == 0);
            mem_rdata       = $urandom;
        end
        vis = mem_rdata_valid;
        inst_start = is; d_cmd_start = ds; d_cmd_write = dw;
        i_addr = ia; d_addr = da; wdata = wd; wmask = wm; mem_cmd_ready = rdy;
        #2;
        if (!m_busy) begin
            gd = ds && (!is || m_streak != MAX_STREAK);
            gi = is && !gd;
            chk("mem_cmd_start", 32'(mem_cmd_start), 32'(is || ds));
            if (is || ds) begin
                chk("mem_addr", mem_addr, gd ? da : ia);
                chk("mem_cmd_write", 32'(mem_cmd_write), 32'(gd && dw));
                if (gd) begin
                    chk("mem_wdata", mem_wdata, wd);
                    chk("mem_wmask", mem_wmask, wm);
                end
            end
            chk("inst_ready", 32'(inst_ready), 32'(gi && rdy));
            chk("d_cmd_ready", 32'(d_cmd_ready), 32'(gd && rdy));
            if (is && ds && rdy) m_pc++;
            if (rdy && gi) begin
                m_streak = 0;
                m_pi++;
                iq.push_back(img(ia));
                m_busy = 1;
                mem_start(ia, lat);
            end else if (rdy && gd) begin
                m_pd++;
                m_streak = is ? ((m_streak + 1 > MAX_STREAK) ? MAX_STREAK : m_streak + 1) : 0;
                if (!dw) begin
                    dq.push_back(img(da));
                    m_busy = 1;
                    mem_start(da, lat);
                end
            end else if (!is) begin
                m_streak = 0;
            end
        end else begin
            chk("busy_mem_cmd_start", 32'(mem_cmd_start), 32'd0);
            chk("busy_inst_ready", 32'(inst_ready), 32'd0);
            chk("busy_d_cmd_ready", 32'(d_cmd_ready), 32'd0);
            if (vis) m_busy = 0;
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) cycle(0, 0, 0, '0, '0, '0, '0, 1, 1, 0);
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        inst_start = 1'b1; d_cmd_start = 1'b1; mem_cmd_ready = 1'b1; mem_rdata_valid = 1'b1;
        m_busy = 0; m_streak = 0; m_pi = '0; m_pd = '0; m_pc = '0;
        iq.delete(); dq.delete();
        #2;
        chk("rst_inst_ready", 32'(inst_ready), 32'd0);
        chk("rst_d_cmd_ready", 32'(d_cmd_ready), 32'd0);
        chk("rst_mem_cmd_start", 32'(mem_cmd_start), 32'd0);
`ifdef MEM_ARB_PERF_EN
        chk("rst_perf_i", perf_i_grants, 32'd0);
        chk("rst_perf_d", perf_d_grants, 32'd0);
        chk("rst_perf_c", perf_conflicts, 32'd0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        inst_start = 1'b0; d_cmd_start = 1'b0; mem_rdata_valid = 1'b0;
    endtask

    // Monitor: every presented response must match the head of its queue
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_inst_valid", 32'(inst_valid), 32'd0);
            chk("rst_rdata_valid", 32'(rdata_valid), 32'd0);
        end else begin
            if (inst_valid) begin
                if (iq.size() == 0) chk("inst_valid_unexpected", 32'd1, 32'd0);
                else chk("inst", inst, iq.pop_front());
            end
            if (rdata_valid) begin
                if (dq.size() == 0) chk("rdata_valid_unexpected", 32'd1, 32'd0);
                else chk("rdata", rdata, dq.pop_front());
            end
        end
    end

    initial begin
        apply_reset();

        // Instruction read, 2-cycle memory latency
        mem_img[32'h100] = 32'h0000_0013;
        cycle(1, 0, 0, 32'h100, '0, '0, '0, 1, 2, 0);
        idle_cycles(4);

        // Simultaneous requests: data wins, instruction served afterwards
        cycle(1, 1, 0, 32'h200, 32'h4000, '0, '0, 1, 1, 0);
        cycle(1, 0, 0, 32'h200, '0, '0, '0, 1, 1, 0);
        cycle(1, 0, 0, 32'h200, '0, '0, '0, 1, 1, 0);
        idle_cycles(3);

        // Starvation guard: 4 data writes then the instruction
        apply_reset();
        for (int k = 0; k < 5; k++)
            cycle(1, 1, 1, 32'h300, 32'h5000 + 32'(k * 4), $urandom, $urandom, 1, 2, 0);
`ifdef MEM_ARB_PERF_EN
        @(posedge clk); #1;
        chk("perf_d_grants", perf_d_grants, 32'd4);
        chk("perf_i_grants", perf_i_grants, 32'd1);
        chk("perf_conflicts", perf_conflicts, 32'd5);
`endif
        idle_cycles(4);

        // Write passes through; instruction accepted the next cycle
        cycle(0, 1, 1, '0, 32'h600, 32'hDEAD_BEEF, 32'h0000_FFFF, 1, 1, 0);
        cycle(1, 0, 0, 32'h700, '0, '0, '0, 1, 1, 0);
        idle_cycles(3);

        // Reset while a data read is outstanding; late response must be dropped
        cycle(0, 1, 0, '0, 32'h800, '0, '0, 1, 3, 0);
        idle_cycles(1);
        apply_reset();
        idle_cycles(4);
        cycle(1, 0, 0, 32'h900, '0, '0, '0, 1, 1, 0);
        idle_cycles(3);

        // Randomized traffic with spurious memory valids while idle
        for (int n = 0; n < 1500; n++)
            cycle($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  {20'h0, $urandom_range(0, 255) * 4}, {20'h1, $urandom_range(0, 255) * 4},
                  $urandom, $urandom, $urandom_range(0, 3) != 0, $urandom_range(1, 3), 1);

        idle_cycles(6);
        chk("inst_queue_drained", 32'(iq.size()), 32'd0);
        chk("data_queue_drained", 32'(dq.size()), 32'd0);
`ifdef MEM_ARB_PERF_EN
        chk("perf_i_final", perf_i_grants, m_pi);
        chk("perf_d_final", perf_d_grants, m_pd);
        chk("perf_c_final", perf_conflicts, m_pc);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MAX_DATA_STREAK, default 4: the number of consecutive data grants allowed while an instruction request waits; range 1..15.
REQ-002 SHALL have ports clk input 1 (system clock) and rst_n input 1 (reset); reset is asynchronous, active-low.
REQ-003 SHALL have instruction-side ports:
- inst_start in 1
- inst_ready out 1
- i_addr in 32
- inst out 32
- inst_valid out 1
REQ-004 SHALL have data-side ports:
- d_cmd_start in 1
- d_cmd_write in 1
- d_cmd_ready out 1
- d_addr in 32
- wdata in 32
- wmask in 32
- rdata out 32
- rdata_valid out 1
REQ-005 SHALL have memory-side ports:
- mem_cmd_start out 1
- mem_cmd_write out 1
- mem_cmd_ready in 1
- mem_addr out 32
- mem_wdata out 32
- mem_wmask out 32
- mem_rdata in 32
- mem_rdata_valid in 1

Function
REQ-006 SHALL multiplex the core's instruction and data ports onto one single-outstanding memory port.
REQ-007 SHALL implement states IDLE, I_WAIT (instruction read outstanding) and D_WAIT (data read outstanding).
REQ-008 Handshake: a command is accepted in a cycle where its start and ready are both 1; the arbiter forwards the command combinationally in IDLE, so acceptance happens in the same cycle.
REQ-009 In IDLE: inst_ready = mem_cmd_ready AND (instruction is granted); d_cmd_ready = mem_cmd_ready AND (data is granted); both ready outputs are 0 outside IDLE.
REQ-010 Grant rule: when only one start is high, that port is granted.
REQ-011 When both starts are high, data is granted, unless streak_cnt equals MAX_DATA_STREAK; in that case instruction is granted.
REQ-012 streak_cnt (4-bit) updates as follows:
- increments on each accepted data command while inst_start is high;
- clears on an accepted instruction command;
- clears when inst_start is low in IDLE;
- saturates at MAX_DATA_STREAK.
REQ-013 mem_addr, mem_wdata, mem_wmask and mem_cmd_write follow the granted port; mem_cmd_write is 0 for instruction grants.
REQ-014 mem_cmd_start is 0 outside IDLE.
REQ-015 On an accepted instruction read: IDLE->I_WAIT.
REQ-016 On an accepted data read: IDLE->D_WAIT.
REQ-017 On an accepted data write: remain in IDLE; no response is generated, and a new command may be accepted in the next cycle.
REQ-018 In I_WAIT: inst = mem_rdata and inst_valid = mem_rdata_valid (combinational); the state returns to IDLE in the cycle mem_rdata_valid is 1.
REQ-019 In D_WAIT: rdata = mem_rdata and rdata_valid = mem_rdata_valid; the state returns to IDLE in the same way.
REQ-020 inst_valid SHALL be 0 outside I_WAIT; rdata_valid SHALL be 0 outside D_WAIT.
REQ-021 A mem_rdata_valid pulse in IDLE is ignored.
REQ-022 Minimum read latency is 1 cycle from acceptance; back-to-back read throughput is one read per (memory latency + 1) cycles.
REQ-023 A start withdrawn before acceptance leaves no state change.

Reset
REQ-024 While rst_n=0: state=IDLE, streak_cnt=0, all ready/valid/start outputs 0, perf counters 0.
REQ-025 Reset mid-read discards the outstanding transaction; the late response is ignored under REQ-021.

Configuration
REQ-026 With MEM_ARB_PERF_EN defined, the block SHALL add outputs perf_i_grants, perf_d_grants and perf_conflicts (32 bits each, wrap at 2^32).
- perf_i_grants counts accepted instruction commands.
- perf_d_grants counts accepted data commands.
- perf_conflicts counts IDLE cycles with both starts high and mem_cmd_ready=1.
REQ-027 Without MEM_ARB_PERF_EN, these ports and counters SHALL not exist, and behaviour is otherwise identical.

Structure
REQ-028 State encodings (ARB_IDLE, ARB_I_WAIT, ARB_D_WAIT) SHALL live in the shared core include alongside the existing MEN_*/INST_* constants.
REQ-029 A sub-module mem_arbiter_perf SHALL hold the counters; it is instantiated only under MEM_ARB_PERF_EN.

Verification
REQ-030 Instruction read only: inst_start=1, i_addr=0x100, memory returns 0x00000013 after 2 cycles -> inst_valid pulses once with inst=0x00000013, and the state is back in IDLE the next cycle.
REQ-031 Simultaneous requests: both starts at i_addr=0x200, d_addr=0x4000 (read), streak 0 -> mem_addr=0x4000, d_cmd_ready=1, inst_ready=0; the instruction is served after rdata_valid.
REQ-032 Starvation: inst_start held while d_cmd_start issues 5 writes, MAX_DATA_STREAK=4 -> the first 4 grants are data and the 5th is instruction at i_addr.
REQ-033 Write: d_cmd_write=1, wdata=0xDEADBEEF, wmask=0x0000FFFF -> passed to memory the same cycle; no rdata_valid; an instruction is accepted the next cycle.
REQ-034 Reset during D_WAIT, then memory asserts mem_rdata_valid -> rdata_valid stays 0 and the state is IDLE.
REQ-035 With MEM_ARB_PERF_EN: scenario of REQ-032 -> perf_d_grants=4, perf_i_grants=1, perf_conflicts=5.
